// File: rtl/mult_timing_leak_monitor_pkg.sv
// Shared definitions for the multiplier timing-leak monitor: FSM encoding and
// the default trial timeout derived from operand width.
package mult_timing_leak_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_REPORT  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 64;

  // A shift-add multiplier needs about 2*WIDTH cycles; the slack covers handshake overhead.
  function automatic int timeout_default(input int width);
    return 2 * width + 8;
  endfunction

endpackage

// File: rtl/mult_timing_leak_monitor_if.sv
// Bundle of trial-control inputs and result/statistics outputs for the leak monitor.
// Optional trace fields appear when LEAK_MONITOR_TRACE_EN is defined.
interface mult_timing_leak_monitor_if #(
  parameter int CNT_W   = 16,
  parameter int TRIAL_W = 32
);

  logic               start;
  logic               doneOne;
  logic               doneTwo;
  logic               clearStats;
  logic [CNT_W-1:0]   latencyOne;
  logic [CNT_W-1:0]   latencyTwo;
  logic [CNT_W-1:0]   skew;
  logic               trialValid;
  logic               timeout;
  logic               leakSeen;
  logic [TRIAL_W-1:0] trialCount;
  logic [TRIAL_W-1:0] leakCount;
  logic [CNT_W-1:0]   maxSkew;
`ifdef LEAK_MONITOR_TRACE_EN
  logic [TRIAL_W-1:0] firstLeakTrial;
  logic [CNT_W-1:0]   firstLeakSkew;

  modport master (
    output start, doneOne, doneTwo, clearStats,
    input  latencyOne, latencyTwo, skew, trialValid, timeout, leakSeen,
           trialCount, leakCount, maxSkew, firstLeakTrial, firstLeakSkew
  );
  modport slave (
    input  start, doneOne, doneTwo, clearStats,
    output latencyOne, latencyTwo, skew, trialValid, timeout, leakSeen,
           trialCount, leakCount, maxSkew, firstLeakTrial, firstLeakSkew
  );
`else
  modport master (
    output start, doneOne, doneTwo, clearStats,
    input  latencyOne, latencyTwo, skew, trialValid, timeout, leakSeen,
           trialCount, leakCount, maxSkew
  );
  modport slave (
    input  start, doneOne, doneTwo, clearStats,
    output latencyOne, latencyTwo, skew, trialValid, timeout, leakSeen,
           trialCount, leakCount, maxSkew
  );
`endif

endinterface

// File: rtl/mult_timing_leak_monitor_leak_latency_capture.sv
// Latches the latency of the first done pulse seen while armed; later pulses in
// the same trial are ignored until the next clear.
module leak_latency_capture #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             arm_i,
  input  logic             clear_i,
  output logic             hit_o,
  output logic             captured_o,
  output logic [CNT_W-1:0] latency_o
);

  logic             captured_q;
  logic [CNT_W-1:0] latency_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign hit_o      = arm_i && done_i && !captured_q;
  assign captured_o = captured_q;
  assign latency_o  = latency_q;

  // The counter lags the done edge by one, so the captured latency is cnt+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      captured_q <= 1'b0;
      latency_q  <= '0;
    end else if (clear_i) begin
      captured_q <= 1'b0;
    end else if (hit_o) begin
      captured_q <= 1'b1;
      latency_q  <= sat_inc(cnt_i);
    end
  end

endmodule

// File: rtl/mult_timing_leak_monitor.sv
// Times start->done for two multiplier copies, reports latency skew per trial and
// keeps leak statistics. Define LEAK_MONITOR_TRACE_EN to record the first leaky trial.
module mult_timing_leak_monitor
  import mult_timing_leak_monitor_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = 16,
  parameter int TRIAL_W = 32,
  parameter int TIMEOUT = timeout_default(WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  mult_timing_leak_monitor_if.slave    mon
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic start_acc, arm;
  logic hitOne, hitTwo, capOne, capTwo;
  logic [CNT_W-1:0] latOne, latTwo;
  logic [CNT_W-1:0] rptLatOne, rptLatTwo, rptSkew;
  logic rptTimeout, rptLeak;
  logic [CNT_W-1:0] holdLatOne_q, holdLatTwo_q, holdSkew_q;
  logic [TRIAL_W-1:0] trialCount_q, trialCount_d, leakCount_q, leakCount_d;
  logic leakSeen_q, leakSeen_d;
  logic [CNT_W-1:0] maxSkew_q, maxSkew_d;
`ifdef LEAK_MONITOR_TRACE_EN
  logic [TRIAL_W-1:0] firstLeakTrial_q, firstLeakTrial_d;
  logic [CNT_W-1:0]   firstLeakSkew_q, firstLeakSkew_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TRIAL_W-1:0] sat_inc_trial(input logic [TRIAL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  assign start_acc = (state_q == ST_IDLE) && mon.start;
  assign arm       = (state_q == ST_MEASURE);

  leak_latency_capture #(.CNT_W(CNT_W)) u_cap_one (
    .clk(clk), .rst(rst), .done_i(mon.doneOne), .cnt_i(cnt_q), .arm_i(arm),
    .clear_i(start_acc), .hit_o(hitOne), .captured_o(capOne), .latency_o(latOne)
  );

  leak_latency_capture #(.CNT_W(CNT_W)) u_cap_two (
    .clk(clk), .rst(rst), .done_i(mon.doneTwo), .cnt_i(cnt_q), .arm_i(arm),
    .clear_i(start_acc), .hit_o(hitTwo), .captured_o(capTwo), .latency_o(latTwo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc)  cnt_q <= '0;
      else if (arm)   cnt_q <= sat_inc_cnt(cnt_q);
    end
  end

  // Leave MEASURE on the same edge the second done is captured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (mon.start) state_d = ST_MEASURE;
      ST_MEASURE: if (((capOne || hitOne) && (capTwo || hitTwo)) || (cnt_q == TIMEOUT_CNT))
                    state_d = ST_REPORT;
      ST_REPORT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign rptLatOne  = capOne ? latOne : '1;
  assign rptLatTwo  = capTwo ? latTwo : '1;
  assign rptSkew    = abs_diff(rptLatOne, rptLatTwo);
  assign rptTimeout = !(capOne && capTwo);
  assign rptLeak    = (capOne && capTwo && (rptSkew != '0)) || (capOne ^ capTwo);

  // Results are live during REPORT and frozen in the hold registers afterwards.
  always_comb begin
    mon.trialValid = 1'b0;
    mon.timeout    = 1'b0;
    mon.latencyOne = holdLatOne_q;
    mon.latencyTwo = holdLatTwo_q;
    mon.skew       = holdSkew_q;
    if (state_q == ST_REPORT) begin
      mon.trialValid = 1'b1;
      mon.timeout    = rptTimeout;
      mon.latencyOne = rptLatOne;
      mon.latencyTwo = rptLatTwo;
      mon.skew       = rptSkew;
    end
    mon.trialCount = trialCount_q;
    mon.leakCount  = leakCount_q;
    mon.leakSeen   = leakSeen_q;
    mon.maxSkew    = maxSkew_q;
`ifdef LEAK_MONITOR_TRACE_EN
    mon.firstLeakTrial = firstLeakTrial_q;
    mon.firstLeakSkew  = firstLeakSkew_q;
`endif
  end

  always_comb begin
    trialCount_d = trialCount_q;
    leakCount_d  = leakCount_q;
    leakSeen_d   = leakSeen_q;
    maxSkew_d    = maxSkew_q;
`ifdef LEAK_MONITOR_TRACE_EN
    firstLeakTrial_d = firstLeakTrial_q;
    firstLeakSkew_d  = firstLeakSkew_q;
`endif
    if (mon.clearStats) begin
      trialCount_d = '0;
      leakCount_d  = '0;
      leakSeen_d   = 1'b0;
      maxSkew_d    = '0;
`ifdef LEAK_MONITOR_TRACE_EN
      firstLeakTrial_d = '0;
      firstLeakSkew_d  = '0;
`endif
    end else if (state_q == ST_REPORT) begin
      trialCount_d = sat_inc_trial(trialCount_q);
      if (rptLeak) begin
        leakCount_d = sat_inc_trial(leakCount_q);
        leakSeen_d  = 1'b1;
`ifdef LEAK_MONITOR_TRACE_EN
        if (!leakSeen_q) begin
          firstLeakTrial_d = sat_inc_trial(trialCount_q);
          firstLeakSkew_d  = rptTimeout ? '1 : rptSkew;
        end
`endif
      end
      if (!rptTimeout && (rptSkew > maxSkew_q)) maxSkew_d = rptSkew;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdLatOne_q <= '0;
      holdLatTwo_q <= '0;
      holdSkew_q   <= '0;
      trialCount_q <= '0;
      leakCount_q  <= '0;
      leakSeen_q   <= 1'b0;
      maxSkew_q    <= '0;
`ifdef LEAK_MONITOR_TRACE_EN
      firstLeakTrial_q <= '0;
      firstLeakSkew_q  <= '0;
`endif
    end else begin
      if (state_q == ST_REPORT) begin
        holdLatOne_q <= rptLatOne;
        holdLatTwo_q <= rptLatTwo;
        holdSkew_q   <= rptSkew;
      end
      trialCount_q <= trialCount_d;
      leakCount_q  <= leakCount_d;
      leakSeen_q   <= leakSeen_d;
      maxSkew_q    <= maxSkew_d;
`ifdef LEAK_MONITOR_TRACE_EN
      firstLeakTrial_q <= firstLeakTrial_d;
      firstLeakSkew_q  <= firstLeakSkew_d;
`endif
    end
  end

endmodule

// File: tb/tb_mult_timing_leak_monitor.sv
// Scoreboard bench for mult_timing_leak_monitor: directed trials push hand-computed
// results; a negedge monitor checks each trial report and the statistics that follow.
module tb_mult_timing_leak_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_timing_leak_monitor_if bus ();

  mult_timing_leak_monitor dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  typedef struct {
    logic [15:0] l1, l2, sk;
    logic        to, chk_sk;
    logic [31:0] tc, lc;
    logic        ls;
    logic [15:0] mx;
    logic [31:0] ft;
    logic [15:0] fs;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Monitor: trial report on the trialValid cycle, statistics on the cycle after.
  initial begin
    exp_t cur;
    bit pending = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 0;
      end else if (pending) begin
        chk("trialValid_pulse", {31'd0, bus.trialValid}, 32'd0);
        chk("trialCount", bus.trialCount, cur.tc);
        chk("leakCount", bus.leakCount, cur.lc);
        chk("leakSeen", {31'd0, bus.leakSeen}, {31'd0, cur.ls});
        chk("maxSkew", {16'd0, bus.maxSkew}, {16'd0, cur.mx});
`ifdef LEAK_MONITOR_TRACE_EN
        chk("firstLeakTrial", bus.firstLeakTrial, cur.ft);
        chk("firstLeakSkew", {16'd0, bus.firstLeakSkew}, {16'd0, cur.fs});
`endif
        pending = 0;
      end else if (bus.trialValid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_trial", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("latencyOne", {16'd0, bus.latencyOne}, {16'd0, cur.l1});
          chk("latencyTwo", {16'd0, bus.latencyTwo}, {16'd0, cur.l2});
          chk("timeout", {31'd0, bus.timeout}, {31'd0, cur.to});
          if (cur.chk_sk) chk("skew", {16'd0, bus.skew}, {16'd0, cur.sk});
          pending = 1;
        end
      end
    end
  end

  // d==0 means that copy never signals done. Statistics arguments are post-trial values.
  task automatic run_trial(input int d1, input int d2, input bit clr,
                           input logic [15:0] sk, input logic to,
                           input logic [31:0] tc, input logic [31:0] lc, input logic ls,
                           input logic [15:0] mx, input logic [31:0] ft, input logic [15:0] fs);
    exp_t e;
    bit seen = 0;
    e.l1 = (d1 == 0) ? 16'hFFFF : 16'(d1);
    e.l2 = (d2 == 0) ? 16'hFFFF : 16'(d2);
    e.sk = sk; e.to = to; e.chk_sk = !to;
    e.tc = tc; e.lc = lc; e.ls = ls; e.mx = mx; e.ft = ft; e.fs = fs;
    exp_q.push_back(e);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      bus.doneOne = (k == d1);
      bus.doneTwo = (k == d2);
      @(posedge clk); #1;
      if (bus.trialValid) begin
        seen = 1;
        break;
      end
    end
    bus.doneOne = 1'b0;
    bus.doneTwo = 1'b0;
    if (!seen) chk("trial_report_wait", 32'd0, 32'd1);
    if (clr) bus.clearStats = 1'b1;
    @(posedge clk); #1 bus.clearStats = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start = 1'b0; bus.doneOne = 1'b0; bus.doneTwo = 1'b0; bus.clearStats = 1'b0;
    #3;
    chk("rst_latencyOne", {16'd0, bus.latencyOne}, 32'd0);
    chk("rst_trialValid", {31'd0, bus.trialValid}, 32'd0);
    chk("rst_trialCount", bus.trialCount, 32'd0);
    chk("rst_maxSkew", {16'd0, bus.maxSkew}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    //        d1  d2 clr  skew  to   tc lc ls mx  ft fs
    run_trial(66, 66, 0, 16'd0, 0,   1, 0, 0, 0,  0, 0);
    run_trial(10, 13, 0, 16'd3, 0,   2, 1, 1, 3,  2, 3);
    run_trial(20,  0, 0, 16'd0, 1,   3, 2, 1, 3,  2, 3);
    run_trial( 0,  0, 0, 16'd0, 1,   4, 2, 1, 3,  2, 3);

    // Async reset in the middle of a measurement clears everything at once.
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_latencyOne", {16'd0, bus.latencyOne}, 32'd0);
    chk("midrst_latencyTwo", {16'd0, bus.latencyTwo}, 32'd0);
    chk("midrst_trialCount", bus.trialCount, 32'd0);
    chk("midrst_leakCount", bus.leakCount, 32'd0);
    chk("midrst_leakSeen", {31'd0, bus.leakSeen}, 32'd0);
    chk("midrst_maxSkew", {16'd0, bus.maxSkew}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    run_trial( 7,  7, 0, 16'd0, 0,   1, 0, 0, 0,  0, 0);

    // Clear coincident with a leaky report wins.
    run_trial( 4,  9, 1, 16'd5, 0,   0, 0, 0, 0,  0, 0);

    run_trial( 1,  1, 0, 16'd0, 0,   1, 0, 0, 0,  0, 0);
    run_trial( 8, 10, 0, 16'd2, 0,   2, 1, 1, 2,  2, 2);
    run_trial( 3,  8, 0, 16'd5, 0,   3, 2, 1, 5,  2, 2);

    repeat (4) @(posedge clk);
    #1 chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1);
  end

endmodule
